// File: rtl/cache_line_refill.sv
// cache_line_refill
//   Miss-service engine for a 2-way set-associative cache. On an accepted
//   miss it optionally writes the dirty victim line back to memory one word
//   at a time, then fetches the missing line word by word and streams each
//   word into the victim way. A one-cycle refill_done pulse closes the
//   operation so the controller can set valid and clear dirty.
//
//   Handshake: a memory request is presented (mem_req=1 with stable
//   mem_we/mem_addr/mem_wdata) until mem_ack pulses for one cycle; the word
//   is complete on the rising edge where mem_ack is sampled high. mem_ack is
//   only honoured in WB and FILL; anywhere else it is ignored.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   miss_req/miss_addr  start request and missing byte address (IDLE only)
//   victim*             way chosen for eviction plus its valid/dirty/tag
//   cache_rd_*          cache array read port used during writeback
//   mem_*               word-wide memory bus (request, write enable,
//                       address, write/read data, completion pulse)
//   refill_*            cache array write port and completion pulse
//   busy                high in every non-IDLE state
module cache_line_refill #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2,
    parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [ADDR_WIDTH-1:0]   miss_addr,
    input  logic                    victim,
    input  logic                    victim_valid,
    input  logic                    victim_dirty,
    input  logic [TAG_WIDTH-1:0]    victim_tag,
    output logic                    cache_rd_way,
    output logic [OFFSET_WIDTH-1:0] cache_rd_idx,
    input  logic [DATA_WIDTH-1:0]   cache_rd_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    refill_we,
    output logic                    refill_way,
    output logic [OFFSET_WIDTH-1:0] refill_idx,
    output logic [DATA_WIDTH-1:0]   refill_data,
    output logic [TAG_WIDTH-1:0]    refill_tag,
    output logic                    refill_done,
    output logic                    busy
);

    localparam int WORDS_PER_LINE = 2 ** OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = OFFSET_WIDTH'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [OFFSET_WIDTH-1:0] cnt;
    logic [OFFSET_WIDTH-1:0] cnt_nxt;

    // Fields captured at accept time; the inputs may change freely afterwards.
    logic [TAG_WIDTH-1:0]    tag_l;
    logic [INDEX_WIDTH-1:0]  index_l;
    logic [TAG_WIDTH-1:0]    victim_tag_l;
    logic                    victim_l;

    logic                    accept;
    logic                    last_word;
    logic [ADDR_WIDTH-1:0]   wb_addr;
    logic [ADDR_WIDTH-1:0]   fill_addr;

    // Byte offset and word offset of the miss address are irrelevant: the
    // whole line is transferred starting at word 0.
    logic                    unused_miss_low;
    assign unused_miss_low = ^miss_addr[OFFSET_WIDTH+1:0];

    assign accept    = (state == IDLE) && miss_req;
    assign last_word = (cnt == CNT_LAST);
    assign wb_addr   = {victim_tag_l, index_l, cnt, 2'b00};
    assign fill_addr = {tag_l, index_l, cnt, 2'b00};

    // State, word counter and latched request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tag_l        <= '0;
            index_l      <= '0;
            victim_tag_l <= '0;
            victim_l     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                tag_l        <= miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                index_l      <= miss_addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
                victim_tag_l <= victim_tag;
                victim_l     <= victim;
            end
        end
    end

    // Next-state and output decode. All outputs are a function of the
    // registered state (plus mem_ack/mem_rdata/cache_rd_data passthroughs),
    // so asserting rst zeroes them immediately without waiting for a clock.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cache_rd_way = 1'b0;
        cache_rd_idx = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        refill_we    = 1'b0;
        refill_way   = 1'b0;
        refill_idx   = '0;
        refill_data  = '0;
        refill_tag   = '0;
        refill_done  = 1'b0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                if (miss_req) begin
                    cnt_nxt = '0;
                    // An invalid line holds nothing worth saving, even if
                    // its dirty bit happens to be set.
                    if (victim_valid && victim_dirty) begin
                        state_nxt = WB;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end

            WB: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = wb_addr;
                cache_rd_way = victim_l;
                cache_rd_idx = cnt;
                mem_wdata    = cache_rd_data;
                if (mem_ack) begin
                    cnt_nxt = cnt + OFFSET_WIDTH'(1);
                    if (last_word) begin
                        state_nxt = FILL;
                    end
                end
            end

            FILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
                if (mem_ack) begin
                    refill_we   = 1'b1;
                    refill_way  = victim_l;
                    refill_idx  = cnt;
                    refill_data = mem_rdata;
                    refill_tag  = tag_l;
                    cnt_nxt     = cnt + OFFSET_WIDTH'(1);
                    if (last_word) begin
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                refill_done = 1'b1;
                refill_way  = victim_l;
                refill_tag  = tag_l;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
